// File: rtl/dump_on_ctrl.sv
// Delayed dump-switch enable: a rising edge on state_start arms a timer, and
// dump_on then goes high for a fixed number of cycles. Further starts are ignored until the pulse completes.
module dump_on_ctrl #(
    parameter int unsigned DLY_CYC = 10,
    parameter int unsigned ON_CYC  = 50
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic state_start,
    output logic dump_on
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ON
    } state_t;

    localparam logic [15:0] DLY_LAST = 16'(DLY_CYC - 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_CYC - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        start_q;
    logic        go_q;
    logic        dump_on_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            go_q      <= 1'b0;
            dump_on_q <= 1'b0;
        end else begin
            start_q <= state_start;
            // Edges are only accepted while already idle, so an edge that coincides
            // with the return from ON is dropped rather than queued.
            go_q    <= state_start & ~start_q & (state_q == IDLE);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (go_q) begin
                        if (DLY_CYC == 0) begin
                            state_q   <= ON;
                            dump_on_q <= 1'b1;
                        end else begin
                            state_q <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        state_q   <= ON;
                        cnt_q     <= '0;
                        dump_on_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        dump_on_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    dump_on_q <= 1'b0;
                end
            endcase
        end
    end

    assign dump_on = dump_on_q;

endmodule

// File: tb/tb_dump_on_ctrl.sv
// Bench for dump_on_ctrl: three parameterisations share one start/reset stream;
// each output is compared every cycle against a pulse-window model.
module tb_dump_on_ctrl;

    logic clk_sys     = 1'b0;
    logic rst_n       = 1'b0;
    logic state_start = 1'b0;
    logic dump_a, dump_b, dump_c;

    always #50 clk_sys = ~clk_sys;

    dump_on_ctrl u_dut_a (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .state_start(state_start),
        .dump_on    (dump_a)
    );

    dump_on_ctrl #(.DLY_CYC(0), .ON_CYC(1)) u_dut_b (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .state_start(state_start),
        .dump_on    (dump_b)
    );

    dump_on_ctrl #(.DLY_CYC(3), .ON_CYC(5)) u_dut_c (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .state_start(state_start),
        .dump_on    (dump_c)
    );

    longint dly[3] = '{10, 0, 3};
    longint on[3]  = '{50, 1, 5};

    // Model: edge index n; an edge accepted at n gives a high window after
    // edges n+dly+1 .. n+dly+on, and the block is deaf through edge n+dly+on+1.
    longint n = 0;
    longint kacc[3];
    longint last_end[3];
    bit     act[3];
    logic   prev = 1'b0;

    int checks = 0;
    int errors = 0;
    int high_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    function automatic logic expv(input int i);
        return act[i] && (n >= kacc[i] + dly[i] + 1) && (n <= kacc[i] + dly[i] + on[i]);
    endfunction

    task automatic model_reset();
        prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act[i]      = 1'b0;
            last_end[i] = -1;
            kacc[i]     = 0;
        end
    endtask

    task automatic model_edge(input logic s);
        logic raw;
        n++;
        if (!rst_n) begin
            model_reset();
        end else begin
            raw  = s && !prev;
            prev = s;
            for (int i = 0; i < 3; i++) begin
                if (raw && n > last_end[i]) begin
                    act[i]      = 1'b1;
                    kacc[i]     = n;
                    last_end[i] = n + dly[i] + on[i] + 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_a"}, {31'd0, dump_a}, {31'd0, expv(0)});
        chk({tag, "_b"}, {31'd0, dump_b}, {31'd0, expv(1)});
        chk({tag, "_c"}, {31'd0, dump_c}, {31'd0, expv(2)});
    endtask

    // Called at a negedge: drive start and reset, let one posedge happen, check.
    task automatic tick(input logic s, input logic r, input string tag);
        state_start = s;
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            compare_all("async_rst");
        end else begin
            rst_n = r;
        end
        @(posedge clk_sys);
        model_edge(s);
        @(negedge clk_sys);
        compare_all(tag);
        if (dump_a) high_cnt++;
    endtask

    initial begin
        model_reset();
        @(negedge clk_sys);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, "in_reset");
        // rst_n released at 1000 ns with start tied low
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, "idle");

        tick(1'b1, 1'b1, "single");
        for (int i = 0; i < 80; i++) tick(1'b0, 1'b1, "single");

        high_cnt = 0;
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b1, "held");
        for (int i = 0; i < 80; i++) tick(1'b0, 1'b1, "held");
        chk("held_width", high_cnt, 32'd50);

        high_cnt = 0;
        tick(1'b1, 1'b1, "double");
        for (int i = 0; i < 29; i++) tick(1'b0, 1'b1, "double");
        tick(1'b1, 1'b1, "double");
        for (int i = 0; i < 80; i++) tick(1'b0, 1'b1, "double");
        chk("double_width", high_cnt, 32'd50);

        tick(1'b1, 1'b1, "mid_on");
        for (int i = 0; i < 31; i++) tick(1'b0, 1'b1, "mid_on");
        chk("mid_on_high", {31'd0, dump_a}, 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "mid_on_rst");
        high_cnt = 0;
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, "after_rst");
        chk("after_rst_width", high_cnt, 32'd0);

        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, "rst_start_hi");
        high_cnt = 0;
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b1, "rel_start_hi");
        chk("rel_start_hi_width", high_cnt, 32'd50);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, "rel_start_hi");

        // toggling start to hit retrigger and return-to-idle boundaries
        for (int i = 0; i < 40; i++) tick(1'(i % 2), 1'b1, "toggle");

        for (int i = 0; i < 3000; i++) begin
            logic s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) != 0);
            tick(s, r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
